// File: rtl/demux_1x8_deser_if.sv
// demux_1x8_deser_if: bundle of the serial input, the parallel output handshake
// and the status signals of the 1-to-8 deserializer.
//   din, din_valid, sync      serial bit stream from the link
//   dout_ready, ovr_clr       consumer-side controls
//   dout, dout_valid          assembled byte and its valid flag
//   sel                       slot the next valid bit will be written to
//   overrun                   sticky "byte dropped" flag
// modport slave  : the deserializer itself
// modport master : whoever drives the stream and consumes the bytes
interface demux_1x8_deser_if;
  logic       din;
  logic       din_valid;
  logic       sync;
  logic       dout_ready;
  logic       ovr_clr;
  logic [7:0] dout;
  logic       dout_valid;
  logic [2:0] sel;
  logic       overrun;

  modport slave (
    input  din, din_valid, sync, dout_ready, ovr_clr,
    output dout, dout_valid, sel, overrun
  );

  modport master (
    output din, din_valid, sync, dout_ready, ovr_clr,
    input  dout, dout_valid, sel, overrun
  );
endinterface

// File: rtl/demux_1x8_deser.sv
// demux_1x8_deser: serial-to-parallel deserializer. A 3-bit slot counter
// steers each valid serial bit into one of eight byte slots; the completed
// byte is offered on a valid/ready handshake. A byte that completes while
// the previous one is still unconsumed is dropped and flagged in overrun.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    demux_1x8_deser_if.slave (serial input, byte output, status)
// MSB_FIRST=0: slot k -> dout[k]; MSB_FIRST=1: slot k -> dout[7-k].
module demux_1x8_deser #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  demux_1x8_deser_if.slave         bus
);

  logic [7:0] shadow;
  logic [7:0] shadow_next;
  logic [7:0] dout_q;
  logic       dout_valid_q;
  logic [2:0] sel_q;
  logic       overrun_q;
  logic [2:0] wr_slot;
  logic [2:0] wr_idx;
  logic       complete;
  logic       load;
  logic       drop;

  // sync forces the incoming bit into slot 0 regardless of the counter.
  always_comb begin
    wr_slot     = bus.sync ? 3'd0 : sel_q;
    wr_idx      = MSB_FIRST ? (3'd7 - wr_slot) : wr_slot;
    shadow_next = shadow;
    shadow_next[wr_idx] = bus.din;
  end

  assign complete = bus.din_valid && !bus.sync && (sel_q == 3'd7);
  assign load     = complete && (!dout_valid_q || bus.dout_ready);
  assign drop     = complete && dout_valid_q && !bus.dout_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow       <= 8'h00;
      dout_q       <= 8'h00;
      dout_valid_q <= 1'b0;
      sel_q        <= 3'd0;
      overrun_q    <= 1'b0;
    end else begin
      if (bus.din_valid) begin
        shadow <= shadow_next;
        // 3-bit counter wraps 7 -> 0 on the completing bit.
        sel_q  <= bus.sync ? 3'd1 : (sel_q + 3'd1);
      end

      if (load) begin
        dout_q       <= shadow_next;
        dout_valid_q <= 1'b1;
      end else if (dout_valid_q && bus.dout_ready) begin
        dout_valid_q <= 1'b0;
      end

      // A drop in the same cycle as a clear must leave the flag set.
      if (drop) begin
        overrun_q <= 1'b1;
      end else if (bus.ovr_clr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.sel        = sel_q;
  assign bus.overrun    = overrun_q;

endmodule
